// File: rtl/rtan_pkg.sv
// Shared definitions for the r*tan(theta) request arbiter: angle indices,
// controller states, owner encoding and the 90 degree saturation value.
`timescale 1ns/1ps
package rtan_pkg;

    localparam logic [2:0] ANG_00      = 3'd0;
    localparam logic [2:0] ANG_15      = 3'd1;
    localparam logic [2:0] ANG_30      = 3'd2;
    localparam logic [2:0] ANG_45      = 3'd3;
    localparam logic [2:0] ANG_60      = 3'd4;
    localparam logic [2:0] ANG_75      = 3'd5;
    localparam logic [2:0] ANG_90      = 3'd6;
    localparam logic [2:0] ANG_ILLEGAL = 3'd7;

    localparam logic signed [10:0] RTAN_MAX = 11'sh3FF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. The side not granted last wins a tie; the
// pointer moves to the other side on every accepted grant.
`timescale 1ns/1ps
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio_b_q;
    logic prio_b_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        grant    = req;
        prio_b_d = prio_b_q;
        if (req == 2'b11) begin
            grant = prio_b_q ? 2'b10 : 2'b01;
        end
        if (accept && (grant != 2'b00)) begin
            prio_b_d = grant[0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/rtan_calc.sv
// Combinational r*tan(theta) for 0..90 degrees in 15 degree steps, using
// fixed-point tangent constants and floor-rounding arithmetic shifts.
`timescale 1ns/1ps
module rtan_calc
    import rtan_pkg::*;
#(
    parameter int R_WIDTH   = 9,
    parameter int OUT_WIDTH = 11
) (
    input  logic signed [R_WIDTH-1:0]   r,
    input  logic        [2:0]           idx,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        inf,
    output logic                        err
);

    localparam int PW = R_WIDTH + 14;

    localparam logic signed [PW-1:0] K15 = PW'(549);
    localparam logic signed [PW-1:0] K30 = PW'(591);
    localparam logic signed [PW-1:0] K60 = PW'(3547);
    localparam logic signed [PW-1:0] K75 = PW'(7643);

    localparam logic signed [OUT_WIDTH-1:0] RMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    logic signed [PW-1:0]        r_ext;
    logic signed [OUT_WIDTH-1:0] q15;
    logic signed [OUT_WIDTH-1:0] q30;
    logic signed [OUT_WIDTH-1:0] q60;
    logic signed [OUT_WIDTH-1:0] q75;

    assign r_ext = PW'(r);

    // >>> on a signed product rounds toward -inf; the cast keeps the low OUT_WIDTH bits.
    assign q15 = OUT_WIDTH'((r_ext * K15) >>> 11);
    assign q30 = OUT_WIDTH'((r_ext * K30) >>> 10);
    assign q60 = OUT_WIDTH'((r_ext * K60) >>> 11);
    assign q75 = OUT_WIDTH'((r_ext * K75) >>> 11);

    always_comb begin
        result = '0;
        inf    = 1'b0;
        err    = 1'b0;
        case (idx)
            ANG_00: result = '0;
            ANG_15: result = q15;
            ANG_30: result = q30;
            ANG_45: result = OUT_WIDTH'(r);
            ANG_60: result = q60;
            ANG_75: result = q75;
            ANG_90: begin
                inf    = 1'b1;
                result = r[R_WIDTH-1] ? -RMAX : RMAX;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rtan_request_arbiter.sv
// Shares one r*tan(theta) calculator between requesters A and B: round-robin
// accept, hold operands for SETTLE_CYCLES, then return a one-cycle valid.
`timescale 1ns/1ps
module rtan_request_arbiter
    import rtan_pkg::*;
#(
    parameter int R_WIDTH       = 9,
    parameter int OUT_WIDTH     = 11,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        req_a,
    input  logic signed [R_WIDTH-1:0]   r_a,
    input  logic        [2:0]           idx_a,
    input  logic                        req_b,
    input  logic signed [R_WIDTH-1:0]   r_b,
    input  logic        [2:0]           idx_b,
    output logic                        ack_a,
    output logic                        ack_b,
    output logic                        rvalid_a,
    output logic                        rvalid_b,
    output logic signed [OUT_WIDTH-1:0] resp_data,
    output logic                        resp_inf,
    output logic                        resp_err,
    output logic                        busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t                      state_q,    state_d;
    logic [3:0]                  cnt_q,      cnt_d;
    logic signed [R_WIDTH-1:0]   r_q,        r_d;
    logic [2:0]                  idx_q,      idx_d;
    owner_t                      owner_q,    owner_d;
    logic                        ack_a_q,    ack_a_d;
    logic                        ack_b_q,    ack_b_d;
    logic                        rvalid_a_q, rvalid_a_d;
    logic                        rvalid_b_q, rvalid_b_d;
    logic signed [OUT_WIDTH-1:0] data_q,     data_d;
    logic                        inf_q,      inf_d;
    logic                        err_q,      err_d;

    logic                        accept;
    logic [1:0]                  grant;
    logic signed [OUT_WIDTH-1:0] calc_data;
    logic                        calc_inf;
    logic                        calc_err;

    assign accept = (state_q == ST_IDLE) && (req_a || req_b);

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({req_b, req_a}),
        .accept  (accept),
        .grant   (grant)
    );

    // Fed only from the operand registers, so requester inputs may change after ack.
    rtan_calc #(
        .R_WIDTH   (R_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_calc (
        .r      (r_q),
        .idx    (idx_q),
        .result (calc_data),
        .inf    (calc_inf),
        .err    (calc_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        idx_d      = idx_q;
        owner_d    = owner_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        data_d     = data_q;
        inf_d      = inf_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = grant[1] ? OWNER_B : OWNER_A;
                    r_d     = grant[1] ? r_b : r_a;
                    idx_d   = grant[1] ? idx_b : idx_a;
                    ack_a_d = grant[0];
                    ack_b_d = grant[1];
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    data_d     = calc_data;
                    inf_d      = calc_inf;
                    err_d      = calc_err;
                    rvalid_a_d = (owner_q == OWNER_A);
                    rvalid_b_d = (owner_q == OWNER_B);
                    cnt_d      = 4'd0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            r_q        <= '0;
            idx_q      <= 3'd0;
            owner_q    <= OWNER_A;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            data_q     <= '0;
            inf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            idx_q      <= idx_d;
            owner_q    <= owner_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            data_q     <= data_d;
            inf_q      <= inf_d;
            err_q      <= err_d;
        end
    end

    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign resp_data = data_q;
    assign resp_inf  = inf_q;
    assign resp_err  = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtan_request_arbiter.sv
// Scoreboard bench: stimulus pushes predicted grants and results into queues,
// a negedge monitor pops and compares whenever the DUT pulses ack or rvalid.
`timescale 1ns/1ps
module tb_rtan_request_arbiter;

    localparam int R_W    = 9;
    localparam int O_W    = 11;
    localparam int SETTLE = 2;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  req_a, req_b;
    logic signed [R_W-1:0] r_a, r_b;
    logic [2:0]            idx_a, idx_b;
    logic                  ack_a, ack_b, rvalid_a, rvalid_b;
    logic signed [O_W-1:0] resp_data;
    logic                  resp_inf, resp_err, busy;

    always #5 clock = ~clock;

    rtan_request_arbiter #(
        .R_WIDTH       (R_W),
        .OUT_WIDTH     (O_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_a     (req_a),
        .r_a       (r_a),
        .idx_a     (idx_a),
        .req_b     (req_b),
        .r_b       (r_b),
        .idx_b     (idx_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .resp_data (resp_data),
        .resp_inf  (resp_inf),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    typedef struct {
        bit owner;
        int data;
        bit inf;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    bit   ack_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ack_cyc_a = 0;
    int   ack_cyc_b = 0;
    bit   last_owner = 1'b1;   // B served last, so A wins the first tie
    exp_t m_e;
    bit   m_w;

    task automatic check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int fdiv(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int wrap(int v);
        logic signed [O_W-1:0] t;
        t = O_W'(v);
        return int'(t);
    endfunction

    // r * tan(theta) with floor rounding, straight from the tangent table.
    function automatic exp_t model(bit owner, int r, int idx);
        exp_t e;
        e.owner = owner;
        e.data  = 0;
        e.inf   = 1'b0;
        e.err   = 1'b0;
        case (idx)
            1: e.data = fdiv(r * 549, 2048);
            2: e.data = fdiv(r * 591, 1024);
            3: e.data = r;
            4: e.data = fdiv(r * 3547, 2048);
            5: e.data = fdiv(r * 7643, 2048);
            6: begin
                e.inf  = 1'b1;
                e.data = (r >= 0) ? 1023 : -1023;
            end
            7: e.err = 1'b1;
            default: e.data = 0;
        endcase
        e.data = wrap(e.data);
        return e;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (ack_a || ack_b) begin
            check("ack_exclusive", int'(ack_a && ack_b), 0);
            if (ack_q.size() == 0) begin
                check("ack_unexpected", int'(ack_b) + 1, 0);
            end else begin
                m_w = ack_q.pop_front();
                check("ack_owner", int'(ack_b), int'(m_w));
            end
            if (ack_a) ack_cyc_a = cyc;
            if (ack_b) ack_cyc_b = cyc;
        end
        if (rvalid_a || rvalid_b) begin
            check("rvalid_exclusive", int'(rvalid_a && rvalid_b), 0);
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", int'(rvalid_b) + 1, 0);
            end else begin
                m_e = exp_q.pop_front();
                check("rvalid_owner", int'(rvalid_b), int'(m_e.owner));
                check("resp_data", int'(resp_data), m_e.data);
                check("resp_inf", int'(resp_inf), int'(m_e.inf));
                check("resp_err", int'(resp_err), int'(m_e.err));
                check("rvalid_latency", cyc - (rvalid_b ? ack_cyc_b : ack_cyc_a), SETTLE);
            end
        end
    end

    task automatic scramble_idle();
        if (!req_a) begin
            r_a   = R_W'($urandom);
            idx_a = 3'($urandom);
        end
        if (!req_b) begin
            r_b   = R_W'($urandom);
            idx_b = 3'($urandom);
        end
    endtask

    // na/nb: how many grants each side keeps its request up for (0 = no request).
    task automatic run_round(int na, int nb, int ra, int ia, int rb, int ib);
        int ca, cb, seen_a, seen_b, guard;
        bit w;
        ca = na;
        cb = nb;
        while (ca > 0 || cb > 0) begin
            if (ca > 0 && cb > 0) w = ~last_owner;
            else                  w = (cb > 0);
            ack_q.push_back(w);
            exp_q.push_back(w ? model(1'b1, rb, ib) : model(1'b0, ra, ia));
            last_owner = w;
            if (w) cb--; else ca--;
        end
        @(negedge clock);
        r_a   = R_W'(ra);
        idx_a = 3'(ia);
        req_a = (na > 0);
        r_b   = R_W'(rb);
        idx_b = 3'(ib);
        req_b = (nb > 0);
        scramble_idle();
        seen_a = 0;
        seen_b = 0;
        guard  = 0;
        while ((req_a || req_b) && guard < 200) begin
            @(negedge clock);
            guard++;
            if (ack_a) seen_a++;
            if (ack_b) seen_b++;
            if (seen_a >= na) req_a = 1'b0;
            if (seen_b >= nb) req_b = 1'b0;
            scramble_idle();
        end
        check("round_ack_timeout", int'(req_a || req_b), 0);
        req_a = 1'b0;
        req_b = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clock);
            scramble_idle();
            guard++;
        end
        check("round_drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard, stray, na, nb;
        reset_n = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        r_a     = '0;
        r_b     = '0;
        idx_a   = 3'd0;
        idx_b   = 3'd0;
        #12;
        check("reset_flags", int'({ack_a, ack_b, rvalid_a, rvalid_b, resp_inf, resp_err, busy}), 0);
        check("reset_data", int'(resp_data), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        run_round(1, 0, 100, 1, 0, 0);
        run_round(1, 0, -100, 1, 0, 0);
        run_round(1, 0, -100, 6, 0, 0);
        run_round(1, 0, 100, 5, 0, 0);
        run_round(2, 2, 37, 2, -81, 4);
        run_round(1, 0, 55, 7, 0, 0);
        run_round(0, 1, 0, 0, 255, 5);
        run_round(1, 0, 255, 6, 0, 0);
        run_round(1, 1, -256, 2, 0, 6);
        run_round(0, 1, 0, 0, -256, 5);
        run_round(1, 0, -1, 1, 0, 0);
        run_round(1, 0, 77, 0, 0, 0);
        run_round(0, 1, 0, 0, 100, 4);

        // Abort an operation mid-SETTLE with an asynchronous reset.
        @(negedge clock);
        req_a = 1'b1;
        r_a   = 9'sd100;
        idx_a = 3'd3;
        ack_q.push_back(1'b0);
        guard = 0;
        while (!ack_a && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("rst_ack_seen", int'(ack_a), 1);
        req_a = 1'b0;
        @(posedge clock);
        #2;
        check("rst_pre_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("rst_async_flags", int'({ack_a, ack_b, rvalid_a, rvalid_b, resp_inf, resp_err, busy}), 0);
        check("rst_async_data", int'(resp_data), 0);
        ack_q.delete();
        last_owner = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clock);
            stray += int'(rvalid_a || rvalid_b || ack_a || ack_b);
        end
        check("rst_no_stale_pulse", stray, 0);
        run_round(1, 1, 10, 3, 20, 3);

        for (int i = 0; i < 40; i++) begin
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 2);
            if (na == 0 && nb == 0) na = 1;
            run_round(na, nb,
                      int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 7)));
        end

        repeat (4) @(negedge clock);
        check("final_queues", ack_q.size() + exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
